reu_dma_engine: RTL and testbench

- REU-style transfer sequencer sitting directly upstream of the bus manager's DMA port.
- Converts one programmed transfer (stash / fetch / swap / verify) into a stream of single-byte C64 bus cycles on the toggle dma_req/dma_ack handshake, plus matching accesses on the local expansion-memory port.
- Register-file logic supplies the addresses, length and mode, and reads back live counters.

---
 rtl/reu_dma_engine.sv | 213 +++++++++++++++++++++
 tb/tb_reu_dma_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reu_dma_engine.sv
// REU transfer sequencer: turns one programmed stash/fetch/swap/verify job into single-byte
// C64 DMA cycles (toggle handshake) and expansion-memory accesses. Define REU_VERIFY_EN for verify mode.
module reu_dma_engine #(
    parameter int REU_ADDR_BITS = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               cfg_mode,
    input  logic [15:0]              cfg_c64_addr,
    input  logic [REU_ADDR_BITS-1:0] cfg_reu_addr,
    input  logic [15:0]              cfg_length,
    input  logic                     cfg_fix_c64,
    input  logic                     cfg_fix_reu,
    output logic                     busy,
    output logic                     done,
    output logic                     verify_error,
    output logic [15:0]              cur_c64_addr,
    output logic [REU_ADDR_BITS-1:0] cur_reu_addr,
    output logic [16:0]              remaining,
    output logic [15:0]              dma_a,
    output logic [7:0]               dma_d,
    output logic                     dma_rw,
    output logic                     dma_req,
    input  logic [7:0]               dma_q,
    input  logic                     dma_ack,
    output logic [REU_ADDR_BITS-1:0] mem_addr,
    output logic [7:0]               mem_wdata,
    output logic                     mem_we,
    output logic                     mem_req,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_ack
);
    typedef enum logic [3:0] {
        IDLE, C_RD, C_WAIT, M_RD, M_WAIT, M_WR, C_WR, ADVANCE, FINISH
    } state_t;

    localparam logic [1:0] MODE_STASH  = 2'd0;
    localparam logic [1:0] MODE_FETCH  = 2'd1;
    localparam logic [1:0] MODE_SWAP   = 2'd2;
    localparam logic [1:0] MODE_VERIFY = 2'd3;

    state_t                   state_q;
    logic [1:0]               mode_q;
    logic                     fix_c64_q, fix_reu_q, abort_q;
    logic [7:0]               a_q, b_q;
    logic                     busy_q, done_q, verr_q;
    logic [15:0]              c64_q;
    logic [REU_ADDR_BITS-1:0] reu_q;
    logic [16:0]              rem_q;
    logic [15:0]              dma_a_q;
    logic [7:0]               dma_d_q;
    logic                     dma_rw_q, dma_req_q;
    logic [REU_ADDR_BITS-1:0] mem_addr_q;
    logic [7:0]               mem_wdata_q;
    logic                     mem_we_q, mem_req_q;

    logic                     ack_match, skip_verify;
    logic [15:0]              c64_d;
    logic [REU_ADDR_BITS-1:0] reu_d;
    logic [16:0]              rem_d;

    // The C64 side is idle only when the toggle pair agrees; this also blocks starts after a mid-cycle reset.
    assign ack_match = (dma_ack == dma_req_q);
    assign c64_d     = fix_c64_q ? c64_q : c64_q + 16'd1;
    assign reu_d     = fix_reu_q ? reu_q : reu_q + REU_ADDR_BITS'(1);
    assign rem_d     = rem_q - 17'd1;

`ifdef REU_VERIFY_EN
    assign skip_verify = 1'b0;
`else
    assign skip_verify = (cfg_mode == MODE_VERIFY);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_STASH;
            fix_c64_q   <= 1'b0;
            fix_reu_q   <= 1'b0;
            abort_q     <= 1'b0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            verr_q      <= 1'b0;
            c64_q       <= 16'd0;
            reu_q       <= '0;
            rem_q       <= 17'd0;
            dma_a_q     <= 16'd0;
            dma_d_q     <= 8'd0;
            dma_rw_q    <= 1'b0;
            dma_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && ack_match) begin
                        busy_q    <= 1'b1;
                        verr_q    <= 1'b0;
                        mode_q    <= cfg_mode;
                        fix_c64_q <= cfg_fix_c64;
                        fix_reu_q <= cfg_fix_reu;
                        if (skip_verify) begin
                            state_q <= FINISH;
                        end else begin
                            c64_q   <= cfg_c64_addr;
                            reu_q   <= cfg_reu_addr;
                            rem_q   <= (cfg_length == 16'd0) ? 17'h10000 : {1'b0, cfg_length};
                            state_q <= (cfg_mode == MODE_FETCH) ? M_RD : C_RD;
                        end
                    end
                end
                C_RD: begin
                    dma_a_q   <= c64_q;
                    dma_rw_q  <= 1'b0;
                    dma_req_q <= ~dma_req_q;
                    state_q   <= C_WAIT;
                end
                C_WR: begin
                    dma_a_q   <= c64_q;
                    dma_d_q   <= b_q;
                    dma_rw_q  <= 1'b1;
                    dma_req_q <= ~dma_req_q;
                    state_q   <= C_WAIT;
                end
                C_WAIT: begin
                    if (ack_match) begin
                        if (dma_rw_q) begin
                            state_q <= ADVANCE;
                        end else begin
                            a_q     <= dma_q;
                            state_q <= (mode_q == MODE_STASH) ? M_WR : M_RD;
                        end
                    end
                end
                M_RD: begin
                    mem_addr_q <= reu_q;
                    mem_we_q   <= 1'b0;
                    mem_req_q  <= 1'b1;
                    state_q    <= M_WAIT;
                end
                M_WR: begin
                    mem_addr_q  <= reu_q;
                    mem_wdata_q <= a_q;
                    mem_we_q    <= 1'b1;
                    mem_req_q   <= 1'b1;
                    state_q     <= M_WAIT;
                end
                M_WAIT: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q <= (mode_q == MODE_SWAP) ? C_WR : ADVANCE;
                        end else begin
                            b_q <= mem_rdata;
                            case (mode_q)
                                MODE_FETCH: state_q <= C_WR;
                                MODE_SWAP:  state_q <= M_WR;
                                default: begin
`ifdef REU_VERIFY_EN
                                    // A mismatch still advances past the failing byte, then stops.
                                    if (mem_rdata != a_q) begin
                                        verr_q  <= 1'b1;
                                        abort_q <= 1'b1;
                                    end
`endif
                                    state_q <= ADVANCE;
                                end
                            endcase
                        end
                    end
                end
                ADVANCE: begin
                    rem_q <= rem_d;
                    c64_q <= c64_d;
                    reu_q <= reu_d;
                    if (rem_d == 17'd0 || abort_q)
                        state_q <= FINISH;
                    else
                        state_q <= (mode_q == MODE_FETCH) ? M_RD : C_RD;
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    abort_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign verify_error = verr_q;
    assign cur_c64_addr = c64_q;
    assign cur_reu_addr = reu_q;
    assign remaining    = rem_q;
    assign dma_a        = dma_a_q;
    assign dma_d        = dma_d_q;
    assign dma_rw       = dma_rw_q;
    assign dma_req      = dma_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign mem_req      = mem_req_q;

endmodule

// File: tb/tb_reu_dma_engine.sv
// Scoreboard bench for reu_dma_engine: stimulus pushes expected bus/memory transactions and
// end-of-transfer status; a negedge monitor pops and compares whenever the DUT presents them.
module tb_reu_dma_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_c64_addr;
    logic [23:0] cfg_reu_addr;
    logic [15:0] cfg_length;
    logic        cfg_fix_c64, cfg_fix_reu;
    logic        busy, done, verify_error;
    logic [15:0] cur_c64_addr;
    logic [23:0] cur_reu_addr;
    logic [16:0] remaining;
    logic [15:0] dma_a;
    logic [7:0]  dma_d;
    logic        dma_rw, dma_req;
    logic [7:0]  dma_q = 8'd0;
    logic        dma_ack = 1'b0;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_req;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_ack = 1'b0;

    reu_dma_engine #(.REU_ADDR_BITS(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
        .cfg_c64_addr(cfg_c64_addr), .cfg_reu_addr(cfg_reu_addr), .cfg_length(cfg_length),
        .cfg_fix_c64(cfg_fix_c64), .cfg_fix_reu(cfg_fix_reu),
        .busy(busy), .done(done), .verify_error(verify_error),
        .cur_c64_addr(cur_c64_addr), .cur_reu_addr(cur_reu_addr), .remaining(remaining),
        .dma_a(dma_a), .dma_d(dma_d), .dma_rw(dma_rw), .dma_req(dma_req),
        .dma_q(dma_q), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct { bit mem; bit wr; logic [31:0] addr; logic [7:0] data; } txn_t;
    typedef struct { logic [15:0] c64; logic [23:0] reu; logic [16:0] rem; bit verr; int lat; } stat_t;
    txn_t  exp_q[$];
    stat_t stat_q[$];

    logic [7:0] c64mem [0:65535];
    logic [7:0] reumem [0:255];
    int   checks = 0;
    int   errors = 0;
    bit   hold_ack = 1'b0;
    bit   expect_idle = 1'b0;
    bit   final_req = 1'b0;
    int   tmo_count = 0;
    int   c_cnt = 0;
    int   m_cnt = 0;

    // C64 bus responder: completes a cycle three clocks after the toggle unless stalled.
    always @(posedge clk) begin
        if (dma_req != dma_ack && !hold_ack) begin
            if (c_cnt == 2) begin
                c_cnt   <= 0;
                dma_ack <= dma_req;
                if (!dma_rw) dma_q <= c64mem[dma_a];
            end else begin
                c_cnt <= c_cnt + 1;
            end
        end
    end

    // Expansion-memory responder: one-cycle ack pulse after one wait cycle.
    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (mem_req && !mem_ack) begin
            if (m_cnt == 1) begin
                m_cnt     <= 0;
                mem_ack   <= 1'b1;
                mem_rdata <= reumem[mem_addr[7:0]];
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that compares.
    initial begin
        int    cyc = 0;
        int    start_cyc = 0;
        int    tmo_ack = 0;
        bit    last_req = 1'b0;
        bit    done_prev = 1'b0;
        bit    final_done = 1'b0;
        logic [15:0] hold_a = 16'd0;
        logic [7:0]  hold_d = 8'd0;
        logic        hold_rw = 1'b0;
        txn_t  e;
        stat_t s;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_ctrl", 64'({busy, done, verify_error, dma_rw, dma_req, mem_req, mem_we}), 64'd0);
                chk("rst_bus", 64'({dma_a, dma_d, mem_addr, mem_wdata}), 64'd0);
                chk("rst_cnt", 64'({cur_c64_addr, cur_reu_addr, remaining}), 64'd0);
                hold_a = 16'd0; hold_d = 8'd0; hold_rw = 1'b0;
            end else begin
                if (tmo_count != tmo_ack) begin
                    chk("wait_timeout", 64'(tmo_count), 64'(tmo_ack));
                    tmo_ack = tmo_count;
                end
                if (dma_req != last_req) begin
                    $display("txn C64 %s a=%04h d=%02h", dma_rw ? "WR" : "RD", dma_a, dma_d);
                    if (exp_q.size() == 0) begin
                        chk("c64_unexpected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("c64_txn", 64'({1'b0, dma_rw, 16'h0, dma_a, dma_rw ? dma_d : 8'h00}),
                            64'({e.mem, e.wr, e.addr, e.wr ? e.data : 8'h00}));
                    end
                    hold_a = dma_a; hold_d = dma_d; hold_rw = dma_rw;
                end else if (dma_req != dma_ack) begin
                    chk("dma_stable", 64'({dma_a, dma_d, dma_rw}), 64'({hold_a, hold_d, hold_rw}));
                end
                if (mem_req && mem_ack) begin
                    $display("txn MEM %s a=%06h d=%02h", mem_we ? "WR" : "RD", mem_addr,
                             mem_we ? mem_wdata : mem_rdata);
                    if (exp_q.size() == 0) begin
                        chk("mem_unexpected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_txn", 64'({1'b1, mem_we, 8'h0, mem_addr, mem_we ? mem_wdata : 8'h00}),
                            64'({e.mem, e.wr, e.addr, e.wr ? e.data : 8'h00}));
                    end
                end
                if (expect_idle) chk("dropped_start", 64'({busy, done}), 64'd0);
                if (start) start_cyc = cyc;
                if (done) begin
                    $display("txn DONE c64=%04h reu=%06h rem=%0d verr=%0b", cur_c64_addr, cur_reu_addr,
                             remaining, verify_error);
                    chk("done_width", 64'(done_prev), 64'd0);
                    if (stat_q.size() == 0) begin
                        chk("done_unexpected", 64'(stat_q.size()), 64'd1);
                    end else begin
                        s = stat_q.pop_front();
                        chk("done_status", 64'({cur_c64_addr, cur_reu_addr, remaining, verify_error, busy}),
                            64'({s.c64, s.reu, s.rem, s.verr, 1'b0}));
                        chk("done_missing_txn", 64'(exp_q.size()), 64'd0);
                        if (s.lat >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(s.lat));
                    end
                end
                if (final_req && !final_done) begin
                    chk("final_txn_queue", 64'(exp_q.size()), 64'd0);
                    chk("final_stat_queue", 64'(stat_q.size()), 64'd0);
                    final_done = 1'b1;
                end
            end
            done_prev = done;
            last_req  = dma_req;
        end
    end

    task automatic push_t(input bit m, input bit w, input logic [31:0] a, input logic [7:0] d);
        txn_t t;
        t.mem = m; t.wr = w; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic push_s(input logic [15:0] c, input logic [23:0] r, input logic [16:0] rem,
                          input bit v, input int lat);
        stat_t s;
        s.c64 = c; s.reu = r; s.rem = rem; s.verr = v; s.lat = lat;
        stat_q.push_back(s);
    endtask

    task automatic run(input logic [1:0] m, input logic [15:0] c, input logic [23:0] r,
                       input logic [15:0] len, input bit fc, input bit fr);
        cfg_mode = m; cfg_c64_addr = c; cfg_reu_addr = r; cfg_length = len;
        cfg_fix_c64 = fc; cfg_fix_reu = fr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        if (!seen) tmo_count++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; cfg_mode = 2'd0; cfg_c64_addr = 16'd0; cfg_reu_addr = 24'd0;
        cfg_length = 16'd0; cfg_fix_c64 = 1'b0; cfg_fix_reu = 1'b0;
        c64mem[16'hC000] = 8'h11; c64mem[16'hC001] = 8'h22; c64mem[16'hC002] = 8'h33;
        c64mem[16'h0400] = 8'hAA; c64mem[16'h2000] = 8'h01; c64mem[16'h2001] = 8'h02;
        c64mem[16'h3000] = 8'h10; c64mem[16'h3001] = 8'h20; c64mem[16'h3002] = 8'h30;
        c64mem[16'h3003] = 8'h40; c64mem[16'h5000] = 8'hA1; c64mem[16'h5001] = 8'hA2;
        c64mem[16'h5002] = 8'hA3; c64mem[16'h5100] = 8'h77; c64mem[16'h6000] = 8'hC3;
        c64mem[16'h6100] = 8'hE7;
        reumem[8'hFF] = 8'h5A; reumem[8'h00] = 8'h55; reumem[8'h40] = 8'h10; reumem[8'h41] = 8'h99;
        reumem[8'h42] = 8'h30; reumem[8'h43] = 8'h40; reumem[8'h90] = 8'h3C;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Stash three bytes.
        push_t(0, 0, 32'hC000, 8'h00); push_t(1, 1, 32'h10, 8'h11);
        push_t(0, 0, 32'hC001, 8'h00); push_t(1, 1, 32'h11, 8'h22);
        push_t(0, 0, 32'hC002, 8'h00); push_t(1, 1, 32'h12, 8'h33);
        push_s(16'hC003, 24'h000013, 17'd0, 1'b0, -1);
        run(2'd0, 16'hC000, 24'h000010, 16'd3, 1'b0, 1'b0);
        wait_done();

        // Fetch with fixed REU address and C64 wrap.
        push_t(1, 0, 32'hFF, 8'h00); push_t(0, 1, 32'hFFFF, 8'h5A);
        push_t(1, 0, 32'hFF, 8'h00); push_t(0, 1, 32'h0000, 8'h5A);
        push_s(16'h0001, 24'h0000FF, 17'd0, 1'b0, -1);
        run(2'd1, 16'hFFFF, 24'h0000FF, 16'd2, 1'b0, 1'b1);
        wait_done();

        // Swap one byte.
        push_t(0, 0, 32'h0400, 8'h00); push_t(1, 0, 32'h0, 8'h00);
        push_t(1, 1, 32'h0, 8'hAA);    push_t(0, 1, 32'h0400, 8'h55);
        push_s(16'h0401, 24'h000001, 17'd0, 1'b0, -1);
        run(2'd2, 16'h0400, 24'h000000, 16'd1, 1'b0, 1'b0);
        wait_done();

        // Stash across the REU all-ones wrap.
        push_t(0, 0, 32'h2000, 8'h00); push_t(1, 1, 32'hFFFFFF, 8'h01);
        push_t(0, 0, 32'h2001, 8'h00); push_t(1, 1, 32'h000000, 8'h02);
        push_s(16'h2002, 24'h000001, 17'd0, 1'b0, -1);
        run(2'd0, 16'h2000, 24'hFFFFFF, 16'd2, 1'b0, 1'b0);
        wait_done();

`ifdef REU_VERIFY_EN
        // Verify with mismatch on the second byte.
        push_t(0, 0, 32'h3000, 8'h00); push_t(1, 0, 32'h40, 8'h00);
        push_t(0, 0, 32'h3001, 8'h00); push_t(1, 0, 32'h41, 8'h00);
        push_s(16'h3002, 24'h000042, 17'd2, 1'b1, -1);
`else
        // Verify disabled: no cycles, counters untouched, done one cycle after acceptance.
        push_s(16'h2002, 24'h000001, 17'd0, 1'b0, 2);
`endif
        run(2'd3, 16'h3000, 24'h000040, 16'd4, 1'b0, 1'b0);
        wait_done();

        // Start while busy is ignored.
        push_t(0, 0, 32'h5000, 8'h00); push_t(1, 1, 32'h80, 8'hA1);
        push_t(0, 0, 32'h5001, 8'h00); push_t(1, 1, 32'h81, 8'hA2);
        push_t(0, 0, 32'h5002, 8'h00); push_t(1, 1, 32'h82, 8'hA3);
        push_s(16'h5003, 24'h000083, 17'd0, 1'b0, -1);
        run(2'd0, 16'h5000, 24'h000080, 16'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        run(2'd1, 16'h7000, 24'h000200, 16'd5, 1'b0, 1'b0);
        wait_done();

        // Align toggle parity so the held write leaves dma_req != dma_ack after reset.
        if (dma_req == 1'b0) begin
            push_t(0, 0, 32'h5100, 8'h00); push_t(1, 1, 32'h84, 8'h77);
            push_s(16'h5101, 24'h000085, 17'd0, 1'b0, -1);
            run(2'd0, 16'h5100, 24'h000084, 16'd1, 1'b0, 1'b0);
            wait_done();
        end

        // Reset with a C64 write outstanding.
        hold_ack = 1'b1;
        push_t(1, 0, 32'h90, 8'h00); push_t(0, 1, 32'h6000, 8'h3C);
        run(2'd1, 16'h6000, 24'h000090, 16'd1, 1'b0, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(posedge clk); #1;
                if (dma_rw && dma_req != dma_ack) seen = 1'b1;
            end
            if (!seen) tmo_count++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Start before the ack catches up is dropped.
        expect_idle = 1'b1;
        run(2'd0, 16'h6100, 24'h0000A0, 16'd1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 hold_ack = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk); #1;
                if (dma_req == dma_ack) seen = 1'b1;
            end
            if (!seen) tmo_count++;
        end
        repeat (2) @(posedge clk);
        #1 expect_idle = 1'b0;

        // Once matched, start is accepted.
        push_t(0, 0, 32'h6100, 8'h00); push_t(1, 1, 32'hA0, 8'hE7);
        push_s(16'h6101, 24'h0000A1, 17'd0, 1'b0, -1);
        run(2'd0, 16'h6100, 24'h0000A0, 16'd1, 1'b0, 1'b0);
        wait_done();

        final_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
